// File: rtl/jtdd_scan2x.sv
// Line-doubling scan converter: each input line is captured into one half of a
// ping-pong buffer while the other half is replayed twice at double pixel rate.
module jtdd_scan2x #(
  parameter int AW     = 9,
  parameter int HS_LEN = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       pxl2_cen,
  input  logic [3:0] base_red,
  input  logic [3:0] base_green,
  input  logic [3:0] base_blue,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic       HS,
  input  logic       VS,
  output logic [3:0] x2_red,
  output logic [3:0] x2_green,
  output logic [3:0] x2_blue,
  output logic       x2_HS,
  output logic       x2_VS,
  output logic       x2_LHBL
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW-1:0] LEN_MAX = '1;
  localparam logic [AW-1:0] HS_END  = AW'(HS_LEN);

  // Word layout: bit 12 = LHBL, bits 11:0 = RGB (zeroed while blanked)
  logic [12:0]   mem [0:2*DEPTH-1];
  logic [12:0]   rd_data_reg;
  logic [12:0]   wr_word;
  logic [AW-1:0] hcnt_reg;
  logic [AW-1:0] rcnt_reg;
  logic [AW-1:0] rcnt_next;
  logic [AW-1:0] linelen_reg;
  logic [AW-1:0] linelen_next;
  logic [AW-1:0] rd_addr_reg;
  logic          wbank_reg;
  logic          hs_l_reg;
  logic          line_start;

  assign line_start   = pxl_cen & HS & ~hs_l_reg;
  assign wr_word      = {LHBL, (LHBL & LVBL) ? {base_red, base_green, base_blue} : 12'h000};
  assign linelen_next = (hcnt_reg == LEN_MAX) ? LEN_MAX : hcnt_reg + AW'(1);

  // Replay counter: restarts on every new input line, otherwise loops over the stored length
  always_comb begin
    rcnt_next = rcnt_reg + AW'(1);
    if (line_start)
      rcnt_next = '0;
    else if (linelen_reg == '0)
      rcnt_next = '0;
    else if (rcnt_reg == linelen_reg - AW'(1))
      rcnt_next = '0;
  end

  // Buffer storage kept free of reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (pxl_cen)
      mem[{wbank_reg, hcnt_reg}] <= wr_word;
    if (pxl2_cen)
      rd_data_reg <= mem[{~wbank_reg, rcnt_reg}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_reg    <= '0;
      rcnt_reg    <= '0;
      linelen_reg <= '0;
      rd_addr_reg <= '0;
      wbank_reg   <= 1'b0;
      hs_l_reg    <= 1'b0;
    end else begin
      if (pxl_cen) begin
        hs_l_reg <= HS;
        if (line_start) begin
          hcnt_reg    <= '0;
          wbank_reg   <= ~wbank_reg;
          linelen_reg <= linelen_next;
        end else begin
          hcnt_reg <= hcnt_reg + AW'(1);
        end
      end
      if (pxl2_cen) begin
        rcnt_reg    <= rcnt_next;
        rd_addr_reg <= rcnt_reg;
      end
    end
  end

  // Output stage; stays dark until at least one input line has been measured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x2_red   <= 4'h0;
      x2_green <= 4'h0;
      x2_blue  <= 4'h0;
      x2_LHBL  <= 1'b0;
      x2_HS    <= 1'b0;
      x2_VS    <= 1'b0;
    end else if (pxl2_cen) begin
      if (linelen_reg == '0) begin
        x2_red   <= 4'h0;
        x2_green <= 4'h0;
        x2_blue  <= 4'h0;
        x2_LHBL  <= 1'b0;
        x2_HS    <= 1'b0;
      end else begin
        x2_red   <= rd_data_reg[11:8];
        x2_green <= rd_data_reg[7:4];
        x2_blue  <= rd_data_reg[3:0];
        x2_LHBL  <= rd_data_reg[12];
        x2_HS    <= rd_addr_reg < HS_END;
      end
      if (rcnt_reg == '0)
        x2_VS <= VS;
    end
  end

endmodule

// File: tb/tb_jtdd_scan2x.sv
// Randomized bench for jtdd_scan2x: a line-level model predicts every output
// sample from the recorded input lines and the times of their line starts.
module tb_jtdd_scan2x;

  localparam int AW     = 9;
  localparam int HS_LEN = 28;
  localparam int DEPTH  = 1 << AW;
  localparam int MAXLEN = DEPTH - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       pxl2_cen = 1'b0;
  logic [3:0] base_red = 4'h0;
  logic [3:0] base_green = 4'h0;
  logic [3:0] base_blue = 4'h0;
  logic       LHBL = 1'b0;
  logic       LVBL = 1'b0;
  logic       HS = 1'b0;
  logic       VS = 1'b0;
  logic [3:0] x2_red;
  logic [3:0] x2_green;
  logic [3:0] x2_blue;
  logic       x2_HS;
  logic       x2_VS;
  logic       x2_LHBL;

  always #5 clk = ~clk;

  jtdd_scan2x #(.AW(AW), .HS_LEN(HS_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pxl2_cen(pxl2_cen),
    .base_red(base_red), .base_green(base_green), .base_blue(base_blue),
    .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
    .x2_red(x2_red), .x2_green(x2_green), .x2_blue(x2_blue),
    .x2_HS(x2_HS), .x2_VS(x2_VS), .x2_LHBL(x2_LHBL)
  );

  always @(posedge clk) begin
    if (pxl_cen && !pxl2_cen) begin
      $display("FAIL cen_rule pxl_cen active without pxl2_cen");
      $fatal(1);
    end
  end

  int errors = 0;
  int checks = 0;
  int tick = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s tick=%0d got=%0h expected=%0h", tag, tick, got, exp);
    end
  endtask

  // Reference model: completed lines with the pxl2 tick of their line start
  int          cnt, nstarts, cur_s, cur_len, cur_ord, prv_s, prv_len, prv_ord;
  bit          hs_prev;
  logic        exp_vs;
  logic [12:0] line_w [0:DEPTH-1];
  logic [12:0] cur_d  [0:DEPTH-1];
  logic [12:0] prv_d  [0:DEPTH-1];

  task automatic model_reset();
    cnt = 0; nstarts = 0; hs_prev = 0; exp_vs = 1'b0;
    cur_s = 0; cur_len = 1; cur_ord = 0;
    prv_s = 0; prv_len = 1; prv_ord = 0;
  endtask

  task automatic check_word(input logic [12:0] ew, input int p);
    check_eq("x2_rgb", {x2_red, x2_green, x2_blue}, ew[11:0]);
    check_eq("x2_LHBL", x2_LHBL, ew[12]);
    check_eq("x2_HS", x2_HS, p < HS_LEN);
  endtask

  // Called just after every pxl2_cen edge
  task automatic model_step();
    int          r, p;
    logic [12:0] w;
    tick++;
    r = (nstarts == 0) ? 0 : (tick - cur_s - 1) % cur_len;
    if (r == 0) exp_vs = VS;
    if (pxl_cen) begin
      w = {LHBL, (LHBL && LVBL) ? {base_red, base_green, base_blue} : 12'h000};
      line_w[cnt] = w;
      if (HS && !hs_prev) begin
        prv_d = cur_d; prv_s = cur_s; prv_len = cur_len; prv_ord = cur_ord;
        cur_d = line_w; cur_s = tick;
        cur_len = (cnt + 1 > MAXLEN) ? MAXLEN : cnt + 1;
        nstarts++; cur_ord = nstarts; cnt = 0;
      end else begin
        cnt = (cnt + 1) % DEPTH;
      end
      hs_prev = HS;
    end
    check_eq("x2_VS", x2_VS, exp_vs);
    if (nstarts == 0 || (nstarts == 1 && tick == cur_s)) begin
      check_word(13'h0, HS_LEN);
    end else if (tick >= cur_s + 2 && cur_ord >= 2) begin
      p = (tick - cur_s - 2) % cur_len;
      check_word(cur_d[p], p);
    end else if (tick < cur_s + 2 && prv_ord >= 2) begin
      p = (tick - prv_s - 2) % prv_len;
      check_word(prv_d[p], p);
    end
  endtask

  task automatic drive_pixel(input logic [11:0] rgb, input logic lhbl, input logic lvbl,
                             input logic hs, input logic vs);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      {base_red, base_green, base_blue} = rgb;
      LHBL = lhbl; LVBL = lvbl; HS = hs; VS = vs;
      pxl_cen  = (c == 0);
      pxl2_cen = (c == 0) || (c == 2);
      @(posedge clk);
      #1;
      if (pxl2_cen) model_step();
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rgb", {x2_red, x2_green, x2_blue}, 12'h000);
    check_eq("rst_LHBL", x2_LHBL, 1'b0);
    check_eq("rst_HS", x2_HS, 1'b0);
    check_eq("rst_VS", x2_VS, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: index pattern, 1: random colours, 2: vertical blank with white input
  task automatic drive_line(input int len, input int mode, input logic vs, input int rst_at);
    int          hb_end;
    logic [11:0] rgb;
    hb_end = (mode == 0) ? 256 : $urandom_range(150, 300);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) async_reset();
      rgb = (mode == 0) ? 12'(i) : (mode == 2) ? 12'hFFF : 12'($urandom);
      drive_pixel(rgb, i < hb_end, mode != 2, (i == len - 1) || (i < 20), vs);
    end
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      {base_red, base_green, base_blue} = 12'($urandom);
      LHBL = 1'($urandom); LVBL = 1'($urandom); HS = 1'($urandom); VS = 1'($urandom);
      pxl2_cen = 1'($urandom);
      pxl_cen  = pxl2_cen & 1'($urandom);
      @(posedge clk);
      #1;
      check_eq("hold_rgb", {x2_red, x2_green, x2_blue}, 12'h000);
      check_eq("hold_LHBL", x2_LHBL, 1'b0);
      check_eq("hold_HS", x2_HS, 1'b0);
      check_eq("hold_VS", x2_VS, 1'b0);
    end
    @(negedge clk);
    pxl_cen = 1'b0; pxl2_cen = 1'b0; HS = 1'b0;
    rst_n = 1'b1;

    for (int k = 0; k < 100; k++)
      drive_pixel(12'($urandom), 1'($urandom), 1'b1, 1'b0, 1'($urandom));

    repeat (4) drive_line(384, 0, 1'b0, -1);
    repeat (3) drive_line(384, 1, 1'($urandom), -1);
    drive_line(384, 2, 1'b1, -1);
    repeat (2) drive_line(384, 0, 1'b0, -1);
    repeat (4) drive_line(320, 1, 1'b0, -1);
    drive_line(320, 1, 1'b0, 50);
    repeat (4) drive_line(320, 1, 1'($urandom), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
